// File: rtl/bcd_op_sequencer_if.sv
// Request/response bundle between a BCD operation requester and bcd_op_sequencer.
// master = requester side, slave = sequencer side.
interface bcd_op_sequencer_if #(
   parameter int DIGITS = 8
);
   localparam int W = 4 * DIGITS;

   logic         req_valid;
   logic         req_ready;
   logic [1:0]   req_op;
   logic [W-1:0] req_a;
   logic [W-1:0] req_b;

   logic         rsp_valid;
   logic         rsp_ready;
   logic [W-1:0] rsp_result;
   logic         rsp_neg;
   logic         rsp_ovf;
   logic         rsp_err;

   modport master (
      output req_valid, req_op, req_a, req_b, rsp_ready,
      input  req_ready, rsp_valid, rsp_result, rsp_neg, rsp_ovf, rsp_err
   );

   modport slave (
      input  req_valid, req_op, req_a, req_b, rsp_ready,
      output req_ready, rsp_valid, rsp_result, rsp_neg, rsp_ovf, rsp_err
   );
endinterface

// File: rtl/bcd_op_sequencer.sv
// Sequences BCD add/sub/mul; add/sub/reject answer the cycle after accept, mul DIGITS edges after accept.
// One op in flight; the response is held until rsp_ready, and no request is taken until it is consumed.
module bcd_op_sequencer #(
   parameter int DIGITS = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              abort,
   bcd_op_sequencer_if.slave bus,
   output logic              busy
);
   localparam int W     = 4 * DIGITS;
   localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;
   localparam logic [1:0] OP_RSV = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_MUL,
      ST_RESP
   } state_t;

   typedef struct packed {
      logic         vld;
      logic [W-1:0] result;
      logic         neg;
      logic         ovf;
      logic         err;
   } rsp_t;

   function automatic logic digits_ok(input logic [W-1:0] x);
      logic ok;
      ok = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (x[4*i +: 4] > 4'd9) ok = 1'b0;
      end
      return ok;
   endfunction

   function automatic logic [W-1:0] nines(input logic [W-1:0] x);
      logic [W-1:0] r;
      r = '0;
      for (int i = 0; i < DIGITS; i++) begin
         r[4*i +: 4] = 4'd9 - x[4*i +: 4];
      end
      return r;
   endfunction

   // Ripple decimal adder; MSB of the return value is the decimal carry-out.
   function automatic logic [W:0] bcd_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic cin);
      logic         c;
      logic [4:0]   s;
      logic [W-1:0] r;
      c = cin;
      r = '0;
      for (int i = 0; i < DIGITS; i++) begin
         s = {1'b0, x[4*i +: 4]} + {1'b0, y[4*i +: 4]} + {4'd0, c};
         if (s > 5'd9) begin
            s = s + 5'd6;
            c = 1'b1;
         end else begin
            c = 1'b0;
         end
         r[4*i +: 4] = s[3:0];
      end
      return {c, r};
   endfunction

   // DIGITS x 1 digit product; the top nibble is the digit that falls off the result width.
   function automatic logic [W+3:0] bcd_mul1(input logic [W-1:0] x, input logic [3:0] m);
      logic [6:0]   p;
      logic [3:0]   c;
      logic [W-1:0] r;
      c = '0;
      r = '0;
      for (int i = 0; i < DIGITS; i++) begin
         p = {3'd0, x[4*i +: 4]} * {3'd0, m} + {3'd0, c};
         r[4*i +: 4] = 4'(p % 7'd10);
         c           = 4'(p / 7'd10);
      end
      return {c, r};
   endfunction

   state_t           state_q, state_d;
   logic [W-1:0]     acc_q, acc_d;
   logic [W-1:0]     mcand_q, mcand_d;
   logic [W-1:0]     mplier_q, mplier_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ovf_q, ovf_d;
   rsp_t             rsp_q, rsp_d;

   logic             accept;
   logic             req_ok;
   logic             is_sub;
   logic [W:0]       addsub;
   logic [W+3:0]     pp;
   logic [W:0]       acc_sum;
   logic             step_ovf;

   assign bus.req_ready = (state_q == ST_IDLE) && !abort;
   assign accept        = bus.req_valid && bus.req_ready;
   assign req_ok        = digits_ok(bus.req_a) && digits_ok(bus.req_b) && (bus.req_op != OP_RSV);
   assign is_sub        = (bus.req_op == OP_SUB);
   assign addsub        = bcd_add(bus.req_a, is_sub ? nines(bus.req_b) : bus.req_b, is_sub);

   assign pp       = bcd_mul1(mcand_q, mplier_q[3:0]);
   assign acc_sum  = bcd_add(acc_q, pp[W-1:0], 1'b0);
   // Magnitude overflow: accumulate carry, lost partial-product digit, or a live multiplicand digit pushed out.
   assign step_ovf = acc_sum[W]
                   | ((pp[W+3:W] != 4'd0) && (mplier_q[3:0] != 4'd0))
                   | ((mcand_q[W-1:W-4] != 4'd0) && (mplier_q[W-1:4] != '0));

   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      cnt_d    = cnt_q;
      ovf_d    = ovf_q;
      rsp_d    = rsp_q;

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               if (!req_ok) begin
                  rsp_d   = '{vld: 1'b1, result: '0, neg: 1'b0, ovf: 1'b0, err: 1'b1};
                  state_d = ST_RESP;
               end else if (bus.req_op == OP_MUL) begin
                  acc_d    = '0;
                  mcand_d  = bus.req_a;
                  mplier_d = bus.req_b;
                  cnt_d    = '0;
                  ovf_d    = 1'b0;
                  state_d  = ST_MUL;
               end else begin
                  rsp_d.vld    = 1'b1;
                  rsp_d.result = addsub[W-1:0];
                  rsp_d.neg    = (addsub[W-1:W-4] == 4'd9);
                  rsp_d.ovf    = (bus.req_op == OP_ADD) && addsub[W];
                  rsp_d.err    = 1'b0;
                  state_d      = ST_RESP;
               end
            end
         end

         ST_MUL: begin
            acc_d    = acc_sum[W-1:0];
            mcand_d  = {mcand_q[W-5:0], 4'd0};
            mplier_d = {4'd0, mplier_q[W-1:4]};
            cnt_d    = cnt_q + 1'b1;
            ovf_d    = ovf_q | step_ovf;
            if (cnt_q == CNT_W'(DIGITS - 1)) begin
               rsp_d.vld    = 1'b1;
               rsp_d.result = acc_sum[W-1:0];
               rsp_d.neg    = (acc_sum[W-1:W-4] == 4'd9);
               rsp_d.ovf    = ovf_q | step_ovf;
               rsp_d.err    = 1'b0;
               state_d      = ST_RESP;
            end
         end

         ST_RESP: begin
            if (bus.rsp_ready) begin
               rsp_d.vld = 1'b0;
               state_d   = ST_IDLE;
            end
         end

         default: state_d = ST_IDLE;
      endcase

      if (abort) begin
         rsp_d.vld = 1'b0;
         state_d   = ST_IDLE;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
         ovf_q    <= 1'b0;
         rsp_q    <= '0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         cnt_q    <= cnt_d;
         ovf_q    <= ovf_d;
         rsp_q    <= rsp_d;
      end
   end

   assign bus.rsp_valid  = rsp_q.vld;
   assign bus.rsp_result = rsp_q.result;
   assign bus.rsp_neg    = rsp_q.neg;
   assign bus.rsp_ovf    = rsp_q.ovf;
   assign bus.rsp_err    = rsp_q.err;
   assign busy           = (state_q != ST_IDLE);
endmodule

// File: tb/tb_bcd_op_sequencer.sv
// Directed bench for bcd_op_sequencer: stimulus queues expected responses, a negedge monitor
// pops and compares each response as it is consumed.
module tb_bcd_op_sequencer;
   localparam int DIGITS = 8;
   localparam int W      = 4 * DIGITS;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;
   localparam logic [1:0] OP_RSV = 2'b11;

   typedef struct packed {
      logic [W-1:0] res;
      logic         neg;
      logic         ovf;
      logic         err;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   logic abort;
   logic busy;

   int checks   = 0;
   int errors   = 0;
   int cyc      = 0;
   int last_acc = 0;

   exp_t  exp_q[$];
   string name_q[$];

   bcd_op_sequencer_if #(.DIGITS(DIGITS)) bus ();

   bcd_op_sequencer #(.DIGITS(DIGITS)) dut (
      .clk   (clk),
      .reset (reset),
      .abort (abort),
      .bus   (bus),
      .busy  (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: a response is consumed at the next rising edge whenever valid && ready here.
   always @(negedge clk) begin
      exp_t  got;
      exp_t  e;
      string nm;
      if (!reset && bus.rsp_valid && bus.rsp_ready) begin
         got = {bus.rsp_result, bus.rsp_neg, bus.rsp_ovf, bus.rsp_err};
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_rsp: got res=%h neg=%b ovf=%b err=%b expected no response",
                     got.res, got.neg, got.ovf, got.err);
         end else begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            if (got !== e) begin
               errors++;
               $display("FAIL %s: got res=%h neg=%b ovf=%b err=%b expected res=%h neg=%b ovf=%b err=%b",
                        nm, got.res, got.neg, got.ovf, got.err, e.res, e.neg, e.ovf, e.err);
            end
         end
      end
   end

   task automatic send(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      int n;
      n = 0;
      while (!bus.req_ready && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("req_ready_wait", 64'(bus.req_ready), 64'd1);
      bus.req_op    = op;
      bus.req_a     = a;
      bus.req_b     = b;
      bus.req_valid = 1'b1;
      @(posedge clk);
      #1;
      last_acc      = cyc;
      bus.req_valid = 1'b0;
      bus.req_a     = $urandom;
      bus.req_b     = $urandom;
      bus.req_op    = 2'($urandom_range(0, 3));
   endtask

   // exp_edges = rising edges after the accept edge before rsp_valid is seen.
   task automatic do_req(input string name, input logic [1:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] res, input logic neg,
                         input logic ovf, input logic err, input int exp_edges);
      int edges;
      exp_q.push_back('{res: res, neg: neg, ovf: ovf, err: err});
      name_q.push_back(name);
      send(op, a, b);
      if (exp_edges > 0) chk({name, "_busy"}, 64'(busy), 64'd1);
      edges = 0;
      while (!bus.rsp_valid && edges < 40) begin
         @(posedge clk);
         #1;
         edges++;
      end
      chk({name, "_edges"}, 64'(edges), 64'(exp_edges));
   endtask

   initial begin
      int first_acc;
      int n;
      reset         = 1'b1;
      abort         = 1'b0;
      bus.req_valid = 1'b0;
      bus.req_op    = 2'b00;
      bus.req_a     = '0;
      bus.req_b     = '0;
      bus.rsp_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      chk("rst_req_ready", 64'(bus.req_ready), 64'd1);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_result", 64'(bus.rsp_result), 64'd0);
      chk("rst_flags", 64'({bus.rsp_neg, bus.rsp_ovf, bus.rsp_err}), 64'd0);
      @(posedge clk);
      #1;

      do_req("add_123_877", OP_ADD, 32'h00000123, 32'h00000877, 32'h00001000, 1'b0, 1'b0, 1'b0, 0);
      first_acc = last_acc;
      do_req("sub_5_7", OP_SUB, 32'h00000005, 32'h00000007, 32'h99999998, 1'b1, 1'b0, 1'b0, 0);
      chk("accept_spacing", 64'(last_acc - first_acc), 64'd2);
      do_req("add_wrap", OP_ADD, 32'h99999999, 32'h00000001, 32'h00000000, 1'b0, 1'b1, 1'b0, 0);
      do_req("sub_7_5", OP_SUB, 32'h00000007, 32'h00000005, 32'h00000002, 1'b0, 1'b0, 1'b0, 0);
      do_req("add_half_ovf", OP_ADD, 32'h50000000, 32'h50000000, 32'h00000000, 1'b0, 1'b1, 1'b0, 0);

      do_req("mul_1234_5678", OP_MUL, 32'h00001234, 32'h00005678, 32'h07006652, 1'b0, 1'b0, 1'b0, 8);
      do_req("mul_9s_2", OP_MUL, 32'h99999999, 32'h00000002, 32'h99999998, 1'b1, 1'b1, 1'b0, 8);
      do_req("mul_shift_ovf", OP_MUL, 32'h10000000, 32'h00000010, 32'h00000000, 1'b0, 1'b1, 1'b0, 8);
      do_req("mul_3_4", OP_MUL, 32'h00000003, 32'h00000004, 32'h00000012, 1'b0, 1'b0, 1'b0, 8);

      do_req("bad_digit", OP_ADD, 32'h0000A123, 32'h00000001, 32'h00000000, 1'b0, 1'b0, 1'b1, 0);
      do_req("bad_op", OP_RSV, 32'h00000001, 32'h00000002, 32'h00000000, 1'b0, 1'b0, 1'b1, 0);

      // Abort on the 4th multiply iteration edge.
      send(OP_MUL, 32'h00001234, 32'h00005678);
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      abort = 1'b1;
      #1;
      chk("abort_ready_low", 64'(bus.req_ready), 64'd0);
      @(posedge clk);
      #1;
      abort = 1'b0;
      #1;
      chk("abort_req_ready", 64'(bus.req_ready), 64'd1);
      chk("abort_busy", 64'(busy), 64'd0);
      n = 0;
      repeat (15) begin
         @(posedge clk);
         #1;
         if (bus.rsp_valid) n++;
      end
      chk("abort_no_rsp", 64'(n), 64'd0);

      // Abort together with a request in IDLE must not accept it.
      abort         = 1'b1;
      bus.req_op    = OP_ADD;
      bus.req_a     = 32'h00000001;
      bus.req_b     = 32'h00000001;
      bus.req_valid = 1'b1;
      #1;
      chk("abort_idle_ready", 64'(bus.req_ready), 64'd0);
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      abort         = 1'b0;
      chk("abort_idle_busy", 64'(busy), 64'd0);
      chk("abort_idle_rsp", 64'(bus.rsp_valid), 64'd0);

      // Backpressure: response must hold for 5 cycles.
      bus.rsp_ready = 1'b0;
      do_req("bp_mul", OP_MUL, 32'h00001234, 32'h00005678, 32'h07006652, 1'b0, 1'b0, 1'b0, 8);
      repeat (5) begin
         chk("bp_valid", 64'(bus.rsp_valid), 64'd1);
         chk("bp_result", 64'(bus.rsp_result), 64'h07006652);
         chk("bp_flags", 64'({bus.rsp_neg, bus.rsp_ovf, bus.rsp_err}), 64'd0);
         chk("bp_req_ready", 64'(bus.req_ready), 64'd0);
         @(posedge clk);
         #1;
      end
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("bp_released", 64'(bus.rsp_valid), 64'd0);
      chk("bp_ready_after", 64'(bus.req_ready), 64'd1);

      // Asynchronous reset in the middle of a multiply.
      send(OP_MUL, 32'h99999999, 32'h00000002);
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      chk("mid_mul_busy", 64'(busy), 64'd1);
      #2;
      reset = 1'b1;
      #1;
      chk("arst_busy", 64'(busy), 64'd0);
      chk("arst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
      chk("arst_result", 64'(bus.rsp_result), 64'd0);
      chk("arst_flags", 64'({bus.rsp_neg, bus.rsp_ovf, bus.rsp_err}), 64'd0);
      chk("arst_req_ready", 64'(bus.req_ready), 64'd1);
      @(posedge clk);
      #1;
      reset = 1'b0;
      n = 0;
      repeat (12) begin
         @(posedge clk);
         #1;
         if (bus.rsp_valid) n++;
      end
      chk("arst_no_rsp", 64'(n), 64'd0);

      n = 0;
      while (exp_q.size() != 0 && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("queue_drained", 64'(exp_q.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/bcd_op_sequencer.md
Name: bcd_op_sequencer

Overview:
Request/response controller that sequences the shared 8-digit BCD arithmetic datapath: the combinational 10's-complement BCD adder/subtractor and the 8-digit x 1-digit BCD multiplier.
- Accepts one operation at a time (add, sub, mul) over a valid/ready handshake.
- Runs the digit-serial multiply iterations itself, so keypad/digit-entry logic no longer counts stages.
- Holds the result until the consumer takes it.

Parameters:
DIGITS, 8, number of BCD digits per operand/result; data width is 4*DIGITS.

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
abort  input  1  synchronous cancel of any in-flight or pending operation
req_valid  input  1  request present
req_ready  output  1  request accepted when req_valid && req_ready at a rising edge
req_op  input  2  00 add, 01 sub (a-b), 10 mul, 11 reserved
req_a  input  4*DIGITS  operand A, BCD, 10's complement
req_b  input  4*DIGITS  operand B, BCD, 10's complement
rsp_valid  output  1  response present
rsp_ready  input  1  response consumed when rsp_valid && rsp_ready at a rising edge
rsp_result  output  4*DIGITS  result, BCD, modulo 10^DIGITS
rsp_neg  output  1  top result digit == 9 (10's-complement negative)
rsp_ovf  output  1  unsigned overflow (see rules)
rsp_err  output  1  request rejected: invalid digit or reserved op
busy  output  1  state != IDLE

Behaviour:
- Reset (async): state IDLE. All outputs 0 except req_ready, which is 1 after reset if abort is low. Internal acc, mcand, mplier and cnt are cleared.
- req_ready = (state==IDLE) && !abort. There is no acceptance in the same cycle that a response is consumed.
- States: IDLE, MUL, RESP.
- IDLE, request accepted, valid (all nibbles <=9, op != 11):
  - add/sub: rsp_result <= a+b or a+9comp(b)+1 on the accept edge; go to RESP. rsp_valid is high in the cycle after the accept edge (latency 1).
  - add/sub rsp_ovf = decimal carry-out of the adder for add; 0 for sub.
  - mul: acc<=0, mcand<=a, mplier<=b, cnt<=0, ovf<=0; go to MUL.
- IDLE, request accepted, invalid (any nibble >9, or op 11): rsp_result=0, rsp_err=1, rsp_ovf=0, rsp_neg=0; go to RESP with latency 1. No datapath activity.
- MUL, each edge:
  - acc <= acc + mcand*mplier[3:0], BCD, truncated to DIGITS.
  - mcand <= mcand<<4; mplier <= mplier>>4; cnt <= cnt+1.
  - Exactly DIGITS iterations; fixed latency, no early exit.
  - On the edge where cnt==DIGITS-1, load rsp_result<=final acc and go to RESP. rsp_valid therefore rises DIGITS edges after the accept edge.
- MUL ovf (sticky) is set in an iteration when any of these holds:
  - the accumulate adder carries out;
  - the discarded top digit of the 8x1 partial product is nonzero while mplier[3:0]!=0;
  - a nonzero digit is shifted out of mcand while any remaining mplier digit above [3:0] is nonzero.
  - ovf is defined on operands as unsigned magnitudes. The product is still exact modulo 10^DIGITS for 10's-complement operands.
- rsp_neg = (rsp_result top digit == 9) for all ops, with rsp_err=0.
- RESP:
  - rsp_valid=1; rsp_result, rsp_neg, rsp_ovf and rsp_err are held stable until consumed.
  - rsp_ready high at an edge: rsp_valid<=0 and go to IDLE. req_ready becomes 1 the following cycle.
- abort high at any edge: go to IDLE, drop any in-flight op or pending response, rsp_valid<=0. abort has priority over req_valid, rsp_ready and MUL iteration. No response is ever produced for an aborted op.
- Request inputs are sampled only on the accept edge; later changes during MUL have no effect.
- Reset mid-MUL or mid-RESP behaves as power-on reset immediately (asynchronous).

Test Plan:
- add 00000123+00000877, rsp_ready=1 -> rsp_valid high 1 cycle after accept; result 00001000, neg 0, ovf 0, err 0. The next request is accepted 2 cycles after the first.
- sub 00000005-00000007 -> result 99999998, neg 1, ovf 0, latency 1. Also add 99999999+00000001 -> result 00000000, ovf 1.
- mul 00001234*00005678 -> busy for 8 cycles; rsp_valid rises 8 edges after accept; result 07006652, ovf 0. mul 99999999*00000002 -> result 99999998, ovf 1.
- Invalid digit: req_a=0000A123 with add, or op=11 -> result 00000000, err 1, latency 1. Nothing is computed.
- abort on the 4th MUL edge -> no rsp_valid ever; req_ready=1 the cycle after. An abort asserted with req_valid in IDLE is not accepted.
- Backpressure: rsp_ready=0 for 5 cycles after a mul response -> rsp_valid, result and flags are held constant and req_ready stays 0. Asserting reset mid-MUL clears all outputs asynchronously.
